// File: rtl/alu_ops_pkg.sv
// ALU opcode constants shared with the EX stage, plus the multiply sequencer state encoding.
package alu_ops_pkg;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } seq_state_t;

endpackage

// File: rtl/alu_mult_sequencer_if.sv
// Request, shared-ALU and status signals between the EX stage and the multiply sequencer.
interface alu_mult_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] alu_res;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [2:0]       alu_op;
    logic             alu_sel;
    logic             stall;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;

    modport slave (
        input  start, op_a, op_b, alu_res,
        output alu_a, alu_b, alu_op, alu_sel, stall, busy, done, result
    );

    modport master (
        output start, op_a, op_b, alu_res,
        input  alu_a, alu_b, alu_op, alu_sel, stall, busy, done, result
    );
endinterface

// File: rtl/alu_mult_sequencer.sv
// Shift-add multiplier that borrows the shared EX-stage ALU for its additions,
// stalling the pipeline until the low WIDTH bits of op_a*op_b are ready.
module alu_mult_sequencer
    import alu_ops_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    alu_mult_sequencer_if.slave  bus
);

    seq_state_t       state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] result_q, result_d;

    logic [WIDTH-1:0] alu_a_c;
    logic [WIDTH-1:0] alu_b_c;
    logic [WIDTH-1:0] mplier_shift;
    logic [CNT_W-1:0] count_inc;

    assign mplier_shift = mplier_q >> 1;
    assign count_inc    = count_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        count_d  = count_q;
        result_d = result_q;
        alu_a_c  = '0;
        alu_b_c  = '0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    mcand_d  = bus.op_a;
                    mplier_d = bus.op_b;
                    acc_d    = '0;
                    count_d  = '0;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                alu_a_c  = acc_q;
                alu_b_c  = mplier_q[0] ? mcand_q : '0;
                acc_d    = bus.alu_res;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_shift;
                count_d  = count_inc;
                // Stop early once no multiplier bits remain; the sum just produced is final.
                if ((mplier_shift == '0) || (count_inc == CNT_W'(WIDTH))) begin
                    state_d  = S_DONE;
                    result_d = bus.alu_res;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            count_q  <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            count_q  <= count_d;
            result_q <= result_d;
        end
    end

    // The opcode is pinned to ADD even in IDLE so the ALU never sees an undefined code.
    assign bus.alu_op  = ALU_ADD;
    assign bus.alu_a   = alu_a_c;
    assign bus.alu_b   = alu_b_c;
    assign bus.alu_sel = (state_q == S_RUN);
    assign bus.busy    = (state_q == S_RUN);
    assign bus.stall   = ((state_q == S_IDLE) && bus.start) || (state_q == S_RUN);
    assign bus.done    = (state_q == S_DONE);
    assign bus.result  = result_q;

endmodule

// File: tb/tb_alu_mult_sequencer.sv
// Scoreboard bench: the driver queues the expected product and done cycle per multiply,
// an independent monitor pops and compares on every done pulse.
module tb_alu_mult_sequencer;
    import alu_ops_pkg::*;

    localparam int WIDTH = 32;

    typedef struct {
        logic [WIDTH-1:0] exp_result;
        int               exp_cyc;
        string            name;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   tests;
    int   fails;
    exp_t sb_q[$];

    alu_mult_sequencer_if #(.WIDTH(WIDTH)) bus ();

    alu_mult_sequencer #(.WIDTH(WIDTH), .CNT_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Stand-in for the shared EX-stage ALU.
    assign bus.alu_res = (bus.alu_op == ALU_ADD) ? (bus.alu_a + bus.alu_b) : '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: output decode on every cycle, scoreboard pop on every done.
    always @(negedge clk) begin
        #1;
        if (!rst) begin
            check("alu_op_add", 64'(bus.alu_op), 64'(ALU_ADD));
            if (bus.busy) begin
                check("stall_in_run", 64'(bus.stall), 64'd1);
                check("alu_sel_in_run", 64'(bus.alu_sel), 64'd1);
            end else if (bus.done) begin
                check("stall_in_done", 64'(bus.stall), 64'd0);
            end else begin
                check("stall_in_idle", 64'(bus.stall), 64'(bus.start));
                check("idle_alu_ab", {bus.alu_a, bus.alu_b}, 64'd0);
            end
            if (bus.done) begin
                if (sb_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("[TB] FAIL unexpected_done: got done=1 expected done=0 (cycle %0d)", cyc);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check({e.name, "_result"}, 64'(bus.result), 64'(e.exp_result));
                    check({e.name, "_done_cycle"}, 64'(cyc), 64'(e.exp_cyc));
                    $display("[TB] %s: result=0x%08h at cycle %0d", e.name, bus.result, cyc);
                end
            end
        end
    end

    // Issue a single-cycle start; done is expected after N_RUN+1 edges counting the start edge.
    task automatic issue(input string name, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [WIDTH-1:0] exp, input int n_run);
        exp_t e;
        @(negedge clk);
        bus.op_a  = a;
        bus.op_b  = b;
        bus.start = 1'b1;
        e.exp_result = exp;
        e.exp_cyc    = cyc + 1 + n_run;
        e.name       = name;
        sb_q.push_back(e);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (sb_q.size() != 0) begin
            fails++;
            $display("[TB] FAIL %s_timeout: got %0d pending expected 0 pending", name, sb_q.size());
            sb_q.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int c0;
        cyc       = 0;
        tests     = 0;
        fails     = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.op_a  = '0;
        bus.op_b  = '0;
        repeat (3) @(negedge clk);
        #2;
        check("reset_result", 64'(bus.result), 64'd0);
        check("reset_done", 64'(bus.done), 64'd0);
        check("reset_busy", 64'(bus.busy), 64'd0);
        check("reset_alu_sel", 64'(bus.alu_sel), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        issue("mul_7x6", 32'd7, 32'd6, 32'd42, 3);
        drain("mul_7x6", 20);

        issue("mul_neg1_sq", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32);
        drain("mul_neg1_sq", 50);

        issue("mul_by_zero", 32'h1234_5678, 32'd0, 32'd0, 1);
        drain("mul_by_zero", 20);

        // Second start while RUN must be ignored.
        issue("mul_m3x5", 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1, 3);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        drain("mul_m3x5", 20);
        repeat (5) @(negedge clk);
        #2;
        check("m3x5_result_held", 64'(bus.result), 64'hFFFF_FFF1);

        // Reset in the middle of a 17-cycle multiply discards it.
        @(negedge clk);
        bus.op_a  = 32'h0001_0000;
        bus.op_b  = 32'h0001_0000;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        #2;
        check("midrun_busy", 64'(bus.busy), 64'd1);
        rst = 1'b1;
        #1;
        check("abort_result", 64'(bus.result), 64'd0);
        check("abort_busy", 64'(bus.busy), 64'd0);
        check("abort_done", 64'(bus.done), 64'd0);
        check("abort_alu_sel", 64'(bus.alu_sel), 64'd0);
        check("abort_stall", 64'(bus.stall), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (25) @(negedge clk);
        issue("mul_3x4", 32'd3, 32'd4, 32'd12, 3);
        drain("mul_3x4", 20);

        // start held high: three back-to-back multiplies, one every 4 cycles.
        @(negedge clk);
        c0 = cyc;
        bus.op_a  = 32'd2;
        bus.op_b  = 32'd3;
        bus.start = 1'b1;
        for (int k = 0; k < 3; k++) begin
            exp_t e;
            e.exp_result = 32'd6;
            e.exp_cyc    = c0 + 3 + 4 * k;
            e.name       = $sformatf("b2b_%0d", k);
            sb_q.push_back(e);
        end
        while (cyc < c0 + 11) @(negedge clk);
        bus.start = 1'b0;
        drain("b2b", 20);
        repeat (10) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/alu_mult_sequencer.md
Name: alu_mult_sequencer

Overview:
- Multi-cycle controller that performs 32x32 multiplication (low 32 bits of product) by sequencing the existing shared ALU through repeated ADD operations (shift-add).
- Sits beside the EX stage. While it runs, it owns the ALU operand/opcode inputs through an external mux, and stalls the pipeline until the product is ready.

Parameters:
- WIDTH, 32, operand/result width; equals ALU width.
- CNT_W, 6, width of iteration counter; must hold WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request multiply; sampled only in IDLE.
- op_a  input  WIDTH  multiplicand, two's complement.
- op_b  input  WIDTH  multiplier, two's complement.
- alu_res  input  WIDTH  result returned by the shared ALU.
- alu_a  output  WIDTH  ALU operand A.
- alu_b  output  WIDTH  ALU operand B.
- alu_op  output  3  ALU operation code.
- alu_sel  output  1  1 = sequencer owns ALU inputs (external mux select).
- stall  output  1  hold pipeline.
- busy  output  1  multiply in progress.
- done  output  1  one-cycle pulse: result valid.
- result  output  WIDTH  low WIDTH bits of op_a*op_b; registered and held.

Behaviour:
- Clock and reset: one clock, clk. Reset is rst, asynchronous and active-high.
- Reset values: state=IDLE, result=0, done=0, busy=0, alu_sel=0. Internal acc, mcand, mplier and count are all 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - If start=1 at a clock edge: latch mcand<=op_a, mplier<=op_b, acc<=0, count<=0, then go to RUN.
  - Otherwise stay in IDLE.
- RUN, each cycle:
  - alu_op=3'b010 (ADD), alu_a=acc, alu_b = mplier[0] ? mcand : 0.
  - At the edge: acc<=alu_res, mcand<=mcand<<1, mplier<=mplier>>1 (logical), count<=count+1.
  - Exit to DONE when the shifted mplier is 0 or count+1 == WIDTH.
- RUN cycle count: max(1, index of highest set bit of op_b + 1).
  - op_b=0 gives 1 cycle.
  - Any negative op_b gives WIDTH cycles.
- DONE:
  - Lasts exactly one cycle with done=1; result was loaded from the final acc on the edge entering DONE.
  - Then go to IDLE unconditionally.
- result: holds its value until the next multiply completes; it is never cleared except by rst.
- Arithmetic: all arithmetic is modulo 2^WIDTH. Signed and unsigned low-half products are identical, so no sign handling is needed. ALU overflow is ignored.
- Opcode rule: alu_op is always 3'b010. The sequencer never drives an opcode the ALU leaves undefined, including in IDLE.
- In IDLE, alu_a and alu_b are 0.
- Output decode:
  - alu_sel = (state==RUN).
  - busy = (state==RUN).
  - stall = (state==IDLE & start) | (state==RUN). stall is combinational, so the pipeline freezes in the same cycle the request is issued.
  - done is low whenever the state is not DONE.
- Latency: from the start edge to done is N_RUN+1 edges; done is visible after the (N_RUN+1)th edge.
- start while in RUN or DONE: ignored. No queuing; the requester must re-assert start in IDLE.
- start held high continuously: a new multiply begins on the edge in IDLE following DONE, using the op_a/op_b values present then.
- rst mid-operation: immediate return to IDLE with all reset values. The partial product is discarded and no done pulse is produced.

Decomposition:
- Shared package alu_ops_pkg: ALU opcode constants ALU_AND=3'b000, ALU_OR=3'b001, ALU_ADD=3'b010, ALU_SUB=3'b011, ALU_SLT=3'b111; state encoding constants S_IDLE, S_RUN, S_DONE.
- No sub-module. The ALU is instantiated once at the EX-stage level. The operand mux driven by alu_sel lives there, not in this block.

Test Plan:
- op_a=7, op_b=6, start for one cycle -> 3 RUN cycles, done pulse after edge 4, result=42, stall high during start cycle and RUN.
- op_a=0xFFFFFFFF, op_b=0xFFFFFFFF -> 32 RUN cycles, result=0x00000001, alu_op=3'b010 every cycle.
- op_a=0x12345678, op_b=0 -> 1 RUN cycle, result=0, done after edge 2.
- op_a=-3 (0xFFFFFFFD), op_b=5 -> 3 RUN cycles, result=0xFFFFFFF1. A new start pulse during RUN is ignored: exactly one done, and result is unchanged afterward.
- Start 0x10000*0x10000; after 5 RUN cycles assert rst -> state IDLE, result=0, busy=0, no done. Then 3*4 -> result=12.
- start held high with op_a=2, op_b=3 -> back-to-back multiplies. done pulses repeat every 4 cycles with one IDLE cycle between, result=6, and there is no extra done.
